// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, FSM encoding,
// the round-constant table and the forward S-box.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } ks_state_e;

    // Entry i is the Rcon byte for round i; index 0 and 11..15 are never used.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/key_sub_word.sv
// SubWord for the AES key schedule: four parallel combinational S-box lookups.
module key_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub[31:24] = sbox(word[31:24]);
    assign sub[23:16] = sbox(word[23:16]);
    assign sub[15:8]  = sbox(word[15:8]);
    assign sub[7:0]   = sbox(word[7:0]);

endmodule

// File: rtl/key_expansion.sv
// AES-128 key expansion streaming one round key per handshake (valid/ready).
// Define KEY_STORE_EN to keep all 11 round keys in a readable register file.
module key_expansion
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         busy,
`ifdef KEY_STORE_EN
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key,
`endif
    output logic         done
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    ks_state_e   state, state_nxt;
    logic        hs;
    logic        last_hs;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_rot;
    logic [31:0] n0, n1, n2, n3;

    assign hs      = key_valid && key_ready;
    assign last_hs = hs && (round_num == LAST_RND);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EMIT;
            EMIT:    if (last_hs) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign key_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    assign done      = (state == FINISH);

    // Next-round words; RotWord moves the top byte of w3 to the bottom.
    assign {w0, w1, w2, w3} = round_key;

    key_sub_word u_sub_word (
        .word ({w3[23:0], w3[31:24]}),
        .sub  (sub_rot)
    );

    assign n0 = w0 ^ sub_rot ^ {RCON[round_num + 4'd1], 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            round_key <= '0;
            round_num <= '0;
        end else if (state == IDLE && start) begin
            round_key <= key_in;
            round_num <= '0;
        end else if (hs && !last_hs) begin
            round_key <= {n0, n1, n2, n3};
            round_num <= round_num + 4'd1;
        end
    end

`ifdef KEY_STORE_EN
    logic [127:0] key_store [11];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) key_store[i] <= '0;
        end else if (hs) begin
            key_store[round_num] <= round_key;
        end
    end

    assign rd_key = (rd_addr <= LAST_RND) ? key_store[rd_addr] : '0;
`endif

endmodule
